// File: rtl/apu_issue_master_if.sv
// APU request/response bus between the issuing core and the FPU side.
// The master drives requests and consumes responses; the slave is the responder.
interface apu_issue_master_if #(
  parameter int ID_WIDTH        = 9,
  parameter int NB_ARGS         = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int OPCODE_WIDTH    = 6,
  parameter int FLAGS_IN_WIDTH  = 15,
  parameter int FLAGS_OUT_WIDTH = 5
);
  // Request channel
  logic                          req;
  logic                          gnt;
  logic [ID_WIDTH-1:0]           id;
  logic [NB_ARGS*DATA_WIDTH-1:0] operands;
  logic [OPCODE_WIDTH-1:0]       op;
  logic [FLAGS_IN_WIDTH-1:0]     flags;

  // Response channel
  logic                          rready;
  logic                          rvalid;
  logic [DATA_WIDTH-1:0]         rdata;
  logic [FLAGS_OUT_WIDTH-1:0]    rflags;
  logic [ID_WIDTH-1:0]           rid;

  modport master (
    output req, id, operands, op, flags, rready,
    input  gnt, rvalid, rdata, rflags, rid
  );

  modport slave (
    input  req, id, operands, op, flags, rready,
    output gnt, rvalid, rdata, rflags, rid
  );
endinterface

// File: rtl/apu_issue_master.sv
// Initiator end of the APU protocol: takes core FP commands, issues them as
// tagged requests, matches returned tags to destination registers, buffers the
// responses (the responder ignores rready) and presents them as a writeback
// stream in arrival order while accumulating sticky status flags.
module apu_issue_master #(
  parameter int ID_WIDTH        = 9,
  parameter int NB_ARGS         = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int OPCODE_WIDTH    = 6,
  parameter int FLAGS_IN_WIDTH  = 15,
  parameter int FLAGS_OUT_WIDTH = 5,
  parameter int WADDR_WIDTH     = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,

  // Core command side
  input  logic                          cmd_valid_i,
  output logic                          cmd_ready_o,
  input  logic [NB_ARGS*DATA_WIDTH-1:0] cmd_operands_i,
  input  logic [OPCODE_WIDTH-1:0]       cmd_op_i,
  input  logic [FLAGS_IN_WIDTH-1:0]     cmd_flags_i,
  input  logic [WADDR_WIDTH-1:0]        cmd_waddr_i,

  // APU bus
  apu_issue_master_if.master            apu,

  // Writeback side
  output logic                          wb_valid_o,
  input  logic                          wb_ready_i,
  output logic [DATA_WIDTH-1:0]         wb_data_o,
  output logic [WADDR_WIDTH-1:0]        wb_waddr_o,
  output logic [FLAGS_OUT_WIDTH-1:0]    wb_flags_o,

  // Status
  output logic [FLAGS_OUT_WIDTH-1:0]    fflags_o,
  input  logic                          fflags_clr_i,
  output logic                          busy_o,
  output logic                          err_o
);

  localparam int SLOT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W  = SLOT_W + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t state_q, state_d;

  // Slot table: one entry per outstanding tag
  logic [MAX_OUTSTANDING-1:0] slot_busy_q;
  logic [MAX_OUTSTANDING-1:0] slot_issued_q;
  logic [WADDR_WIDTH-1:0]     slot_waddr_q [MAX_OUTSTANDING];

  // Request payload held until granted
  logic [NB_ARGS*DATA_WIDTH-1:0] operands_q;
  logic [OPCODE_WIDTH-1:0]       op_q;
  logic [FLAGS_IN_WIDTH-1:0]     flags_q;
  logic [SLOT_W-1:0]             id_q;

  // Response FIFO
  logic [DATA_WIDTH-1:0]      fifo_data_q  [MAX_OUTSTANDING];
  logic [FLAGS_OUT_WIDTH-1:0] fifo_flags_q [MAX_OUTSTANDING];
  logic [WADDR_WIDTH-1:0]     fifo_waddr_q [MAX_OUTSTANDING];
  logic [SLOT_W-1:0]          fifo_slot_q  [MAX_OUTSTANDING];
  logic [SLOT_W-1:0]          wr_ptr_q;
  logic [SLOT_W-1:0]          rd_ptr_q;
  logic [CNT_W-1:0]           cnt_q;

  logic [FLAGS_OUT_WIDTH-1:0] fflags_q;
  logic                       err_q;

  logic              free_exists;
  logic [SLOT_W-1:0] free_idx;
  logic              accept;
  logic              grant;
  logic              rid_in_range;
  logic [SLOT_W-1:0] rslot;
  logic              resp_ok;
  logic              push;
  logic              resp_err;
  logic              pop;
  logic [SLOT_W-1:0] head_slot;

  // Lowest-index free slot; scanning downward lets the lowest index win
  always_comb begin
    free_exists = 1'b0;
    free_idx    = '0;
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!slot_busy_q[i]) begin
        free_exists = 1'b1;
        free_idx    = SLOT_W'(i);
      end
    end
  end

  // A new command may be taken while idle, or in the same cycle the pending
  // request is granted so back-to-back requests need no bubble.
  assign cmd_ready_o = free_exists & ((state_q == IDLE) | apu.gnt);
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign grant       = (state_q == REQ) & apu.gnt;

  // Range check done one bit wider so it stays correct when ID_WIDTH is
  // exactly log2(MAX_OUTSTANDING).
  assign rid_in_range = ({1'b0, apu.rid} < (ID_WIDTH + 1)'(MAX_OUTSTANDING));
  assign rslot        = apu.rid[SLOT_W-1:0];
  assign resp_ok      = rid_in_range & slot_busy_q[rslot] & slot_issued_q[rslot];
  assign push         = apu.rvalid & resp_ok;
  assign resp_err     = apu.rvalid & ~resp_ok;

  assign wb_valid_o = (cnt_q != '0);
  assign pop        = wb_valid_o & wb_ready_i;
  assign head_slot  = fifo_slot_q[rd_ptr_q];

  // Request FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (apu.gnt && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the accepted command's payload and tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operands_q <= '0;
      op_q       <= '0;
      flags_q    <= '0;
      id_q       <= '0;
    end else if (accept) begin
      operands_q <= cmd_operands_i;
      op_q       <= cmd_op_i;
      flags_q    <= cmd_flags_i;
      id_q       <= free_idx;
    end
  end

  // Slot lifecycle: allocate on accept, mark issued on grant, retire the
  // issued mark once its response is buffered (a repeat response for the
  // same tag is then an error), free on writeback pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_busy_q   <= '0;
      slot_issued_q <= '0;
    end else begin
      if (pop)    slot_busy_q[head_slot] <= 1'b0;
      if (push)   slot_issued_q[rslot]   <= 1'b0;
      if (grant)  slot_issued_q[id_q]    <= 1'b1;
      if (accept) begin
        slot_busy_q[free_idx]   <= 1'b1;
        slot_issued_q[free_idx] <= 1'b0;
      end
    end
  end

  // Destination register per slot
  always_ff @(posedge clk) begin
    if (accept) slot_waddr_q[free_idx] <= cmd_waddr_i;
  end

  // Response FIFO storage
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q]  <= apu.rdata;
      fifo_flags_q[wr_ptr_q] <= apu.rflags;
      fifo_waddr_q[wr_ptr_q] <= slot_waddr_q[rslot];
      fifo_slot_q[wr_ptr_q]  <= rslot;
    end
  end

  // Response FIFO pointers and occupancy; pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Sticky status flags; a clear coinciding with a pop keeps only the new flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags_q <= '0;
    end else if (pop) begin
      fflags_q <= (fflags_clr_i ? '0 : fflags_q) | wb_flags_o;
    end else if (fflags_clr_i) begin
      fflags_q <= '0;
    end
  end

  // Sticky protocol error on any unmatched response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (resp_err) begin
      err_q <= 1'b1;
    end
  end

  // Head outputs are forced to zero when empty so nothing stale is visible
  assign wb_data_o  = wb_valid_o ? fifo_data_q[rd_ptr_q]  : '0;
  assign wb_waddr_o = wb_valid_o ? fifo_waddr_q[rd_ptr_q] : '0;
  assign wb_flags_o = wb_valid_o ? fifo_flags_q[rd_ptr_q] : '0;

  assign apu.req      = (state_q == REQ);
  assign apu.id       = ID_WIDTH'(id_q);
  assign apu.operands = operands_q;
  assign apu.op       = op_q;
  assign apu.flags    = flags_q;
  assign apu.rready   = 1'b1;

  assign fflags_o = fflags_q;
  assign err_o    = err_q;
  assign busy_o   = (|slot_busy_q) | (state_q == REQ);

endmodule
